// File: rtl/wb_sink.sv
// wb_sink: write-back strobe sink with 8x16 register file and 4-phase bus writer.
// Optional macro WB_SINK_BYPASS_EN forwards same-cycle wbr data to reads and bus latch.
module wb_sink #(
    parameter int DW   = 16,
    parameter int NREG = 8,
    parameter int AW   = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wbr,
    input  logic          wbin,
    input  logic [15:0]   ir,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] addr,
    input  logic [2:0]    ra,
    input  logic [2:0]    rb,
    output logic [DW-1:0] qa,
    output logic [DW-1:0] qb,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_data,
    input  logic          mem_ack,
    output logic          busy,
    output logic          err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        REL  = 2'd2
    } state_t;

    state_t        state;
    logic [DW-1:0] regs [NREG];
    logic          wbr_d;
    logic          wbin_d;
    logic          wbr_rise;
    logic          wbin_rise;
    logic [2:0]    idx;
    logic [DW-1:0] bus_src;

    // Only the register index field of the instruction matters here.
    logic unused_ir;
    assign unused_ir = ^{ir[15:11], ir[7:0]};

    assign idx       = ir[10:8];
    assign wbr_rise  = wbr & ~wbr_d;
    assign wbin_rise = wbin & ~wbin_d;
    assign busy      = (state != IDLE);

`ifdef WB_SINK_BYPASS_EN
    // A write landing this cycle is visible to reads and to the bus latch.
    assign qa      = (wbr_rise && idx == ra) ? wdata : regs[ra];
    assign qb      = (wbr_rise && idx == rb) ? wdata : regs[rb];
    assign bus_src = wbr_rise ? wdata : regs[idx];
`else
    // Reads and the bus latch see the register contents before this edge.
    assign qa      = regs[ra];
    assign qb      = regs[rb];
    assign bus_src = regs[idx];
`endif

    // Strobe history for rising-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            wbr_d  <= 1'b0;
            wbin_d <= 1'b0;
        end else begin
            wbr_d  <= wbr;
            wbin_d <= wbin;
        end
    end

    // Register file: one write per wbr rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wbr_rise) begin
            regs[idx] <= wdata;
        end
    end

    // Bus write FSM: latch on wbin rise, 4-phase req/ack, sticky drop error.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
            err      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (wbin_rise) begin
                        mem_addr <= addr;
                        mem_data <= bus_src;
                        mem_req  <= 1'b1;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (wbin_rise) begin
                        err <= 1'b1;
                    end
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= REL;
                    end
                end
                REL: begin
                    if (wbin_rise) begin
                        err <= 1'b1;
                    end
                    if (!mem_ack) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    mem_req <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule
